// File: rtl/mc_ctrl.sv
// Multi-cycle control unit for a small MIPS-like subset.
// Decodes op/funct per state and sequences FETCH..JMP; outputs are combinational.
//
// Ports:
//   clk, rst (async, active-high)  - clock and reset
//   op, funct, zero                - opcode, function field, ALU zero flag
//   pc_wr, ir_wr, rf_wr, dm_wr     - write enables (forced low while rst=1)
//   npc_op, alu_op, alu_src_b,
//   ext_op, wd_sel, ra_sel         - datapath selects
//   state                          - current state for debug
module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_wr,
    output logic       ir_wr,
    output logic       rf_wr,
    output logic       dm_wr,
    output logic [1:0] npc_op,
    output logic [2:0] alu_op,
    output logic       alu_src_b,
    output logic [1:0] ext_op,
    output logic [1:0] wd_sel,
    output logic [1:0] ra_sel,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH = 4'd0,
        S_DCD   = 4'd1,
        S_MA    = 4'd2,
        S_MR    = 4'd3,
        S_MWB   = 4'd4,
        S_MW    = 4'd5,
        S_EXE   = 4'd6,
        S_AWB   = 4'd7,
        S_BR    = 4'd8,
        S_JMP   = 4'd9
    } state_t;

    state_t r_state;
    state_t w_next;

    // instruction decode
    logic w_rtype;
    logic w_addu, w_subu, w_and, w_or, w_slt, w_jr;
    logic w_r_alu;
    logic w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal;
    logic [2:0] w_alu_r;

    assign w_rtype = (op == 6'b000000);
    assign w_addu  = w_rtype && (funct == 6'b100001);
    assign w_subu  = w_rtype && (funct == 6'b100011);
    assign w_and   = w_rtype && (funct == 6'b100100);
    assign w_or    = w_rtype && (funct == 6'b100101);
    assign w_slt   = w_rtype && (funct == 6'b101010);
    assign w_jr    = w_rtype && (funct == 6'b001000);
    assign w_r_alu = w_addu | w_subu | w_and | w_or | w_slt;

    assign w_ori = (op == 6'b001101);
    assign w_lui = (op == 6'b001111);
    assign w_lw  = (op == 6'b100011);
    assign w_sw  = (op == 6'b101011);
    assign w_beq = (op == 6'b000100);
    assign w_j   = (op == 6'b000010);
    assign w_jal = (op == 6'b000011);

    always_comb begin
        w_alu_r = 3'b000;
        unique case (1'b1)
            w_subu:  w_alu_r = 3'b001;
            w_and:   w_alu_r = 3'b010;
            w_or:    w_alu_r = 3'b011;
            w_slt:   w_alu_r = 3'b100;
            default: w_alu_r = 3'b000;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state logic
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH: w_next = S_DCD;
            S_DCD: begin
                if (w_lw || w_sw) begin
                    w_next = S_MA;
                end else if (w_r_alu || w_ori || w_lui) begin
                    w_next = S_EXE;
                end else if (w_beq) begin
                    w_next = S_BR;
                end else if (w_j || w_jal || w_jr) begin
                    w_next = S_JMP;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MA: begin
                if (w_lw) begin
                    w_next = S_MR;
                end else if (w_sw) begin
                    w_next = S_MW;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MR:    w_next = S_MWB;
            S_EXE:   w_next = S_AWB;
            S_MWB,
            S_MW,
            S_AWB,
            S_BR,
            S_JMP:   w_next = S_FETCH;
            default: w_next = S_FETCH;
        endcase
    end

    // raw enables before reset gating
    logic w_pc, w_ir, w_rf, w_dm;

    always_comb begin
        w_pc      = 1'b0;
        w_ir      = 1'b0;
        w_rf      = 1'b0;
        w_dm      = 1'b0;
        npc_op    = 2'b00;
        alu_op    = 3'b000;
        alu_src_b = 1'b0;
        ext_op    = 2'b00;
        wd_sel    = 2'b00;
        ra_sel    = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_ir = 1'b1;
                w_pc = 1'b1;
            end
            S_MA: begin
                alu_op    = 3'b000;
                alu_src_b = 1'b1;
                ext_op    = 2'b01;
            end
            S_MWB: begin
                w_rf   = 1'b1;
                wd_sel = 2'b01;
                ra_sel = 2'b00;
            end
            S_MW: begin
                w_dm = 1'b1;
            end
            // AWB keeps the EXE operand selects so the result stays stable
            S_EXE,
            S_AWB: begin
                if (w_r_alu) begin
                    alu_src_b = 1'b0;
                    alu_op    = w_alu_r;
                end else if (w_ori) begin
                    alu_src_b = 1'b1;
                    ext_op    = 2'b00;
                    alu_op    = 3'b011;
                end else if (w_lui) begin
                    alu_src_b = 1'b1;
                    ext_op    = 2'b10;
                    alu_op    = 3'b101;
                end
                if (r_state == S_AWB && (w_r_alu || w_ori || w_lui)) begin
                    w_rf   = 1'b1;
                    wd_sel = 2'b00;
                    ra_sel = w_r_alu ? 2'b01 : 2'b00;
                end
            end
            S_BR: begin
                alu_op    = 3'b001;
                alu_src_b = 1'b0;
                ext_op    = 2'b01;
                npc_op    = 2'b01;
                w_pc      = zero;
            end
            S_JMP: begin
                if (w_j || w_jal) begin
                    w_pc   = 1'b1;
                    npc_op = 2'b10;
                end
                if (w_jal) begin
                    w_rf   = 1'b1;
                    ra_sel = 2'b10;
                    wd_sel = 2'b10;
                end
                if (w_jr) begin
                    w_pc   = 1'b1;
                    npc_op = 2'b11;
                end
            end
            default: ;
        endcase
    end

    // reset must block writes even though it decodes as FETCH
    assign pc_wr = w_pc & ~rst;
    assign ir_wr = w_ir & ~rst;
    assign rf_wr = w_rf & ~rst;
    assign dm_wr = w_dm & ~rst;
    assign state = r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: instruction table, random instruction
// stream against a per-instruction-class model, and async reset sequences.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pc_wr, ir_wr, rf_wr, dm_wr;
    logic [1:0] npc_op;
    logic [2:0] alu_op;
    logic       alu_src_b;
    logic [1:0] ext_op, wd_sel, ra_sel;
    logic [3:0] state;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .pc_wr(pc_wr), .ir_wr(ir_wr), .rf_wr(rf_wr), .dm_wr(dm_wr),
        .npc_op(npc_op), .alu_op(alu_op), .alu_src_b(alu_src_b),
        .ext_op(ext_op), .wd_sel(wd_sel), .ra_sel(ra_sel), .state(state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, a, e, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {C_LW, C_SW, C_R, C_ORI, C_LUI, C_BEQ, C_J, C_JAL, C_JR, C_UND} cls_t;

    typedef struct packed {
        logic [3:0] st;
        logic       pc, ir, rf, dm;
        logic [1:0] npc;
        logic [2:0] alu;
        logic       sb;
        logic [1:0] ext, wd, ra;
    } ov_t;

    function automatic cls_t classify(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'h00) begin
            if (f inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h2a}) return C_R;
            if (f == 6'h08) return C_JR;
            return C_UND;
        end
        case (o)
            6'h0d: return C_ORI;
            6'h0f: return C_LUI;
            6'h23: return C_LW;
            6'h2b: return C_SW;
            6'h04: return C_BEQ;
            6'h02: return C_J;
            6'h03: return C_JAL;
            default: return C_UND;
        endcase
    endfunction

    function automatic int cyc(input cls_t c);
        case (c)
            C_LW: return 5;
            C_SW, C_R, C_ORI, C_LUI: return 4;
            C_BEQ, C_J, C_JAL, C_JR: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [2:0] rfn(input logic [5:0] f);
        case (f)
            6'h23: return 3'd1;
            6'h24: return 3'd2;
            6'h25: return 3'd3;
            6'h2a: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // expected outputs at cycle 'step' of an instruction of class c
    function automatic ov_t model(input cls_t c, input int step,
                                  input logic z, input logic [5:0] f);
        ov_t o = '0;
        if (step == 0) begin
            o.pc = 1'b1;
            o.ir = 1'b1;
            return o;
        end
        if (step == 1) begin
            o.st = 4'd1;
            return o;
        end
        case (c)
            C_LW, C_SW: begin
                if (step == 2) begin
                    o.st = 4'd2; o.sb = 1'b1; o.ext = 2'd1;
                end else if (c == C_SW) begin
                    o.st = 4'd5; o.dm = 1'b1;
                end else if (step == 3) begin
                    o.st = 4'd3;
                end else begin
                    o.st = 4'd4; o.rf = 1'b1; o.wd = 2'd1;
                end
            end
            C_R, C_ORI, C_LUI: begin
                o.st = (step == 2) ? 4'd6 : 4'd7;
                if (c == C_R) begin
                    o.alu = rfn(f);
                end else if (c == C_ORI) begin
                    o.sb = 1'b1; o.alu = 3'd3;
                end else begin
                    o.sb = 1'b1; o.ext = 2'd2; o.alu = 3'd5;
                end
                if (step == 3) begin
                    o.rf = 1'b1;
                    o.ra = (c == C_R) ? 2'd1 : 2'd0;
                end
            end
            C_BEQ: begin
                o.st = 4'd8; o.alu = 3'd1; o.ext = 2'd1;
                o.npc = 2'd1; o.pc = z;
            end
            C_J, C_JAL: begin
                o.st = 4'd9; o.pc = 1'b1; o.npc = 2'd2;
                if (c == C_JAL) begin
                    o.rf = 1'b1; o.ra = 2'd2; o.wd = 2'd2;
                end
            end
            C_JR: begin
                o.st = 4'd9; o.pc = 1'b1; o.npc = 2'd3;
            end
            default: ;
        endcase
        return o;
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        int          len;
        logic [19:0] seq;
        int          n_rf;
        int          n_dm;
        int          n_pc;
    } vec_t;

    vec_t tv[14];

    initial begin
        tv[0]  = '{6'h23, 6'h00, 1'b0, 5, {4'd4,4'd3,4'd2,4'd1,4'd0}, 1, 0, 1};
        tv[1]  = '{6'h2b, 6'h00, 1'b0, 4, {4'd0,4'd5,4'd2,4'd1,4'd0}, 0, 1, 1};
        tv[2]  = '{6'h00, 6'h21, 1'b0, 4, {4'd0,4'd7,4'd6,4'd1,4'd0}, 1, 0, 1};
        tv[3]  = '{6'h00, 6'h2a, 1'b0, 4, {4'd0,4'd7,4'd6,4'd1,4'd0}, 1, 0, 1};
        tv[4]  = '{6'h0d, 6'h00, 1'b0, 4, {4'd0,4'd7,4'd6,4'd1,4'd0}, 1, 0, 1};
        tv[5]  = '{6'h0f, 6'h00, 1'b0, 4, {4'd0,4'd7,4'd6,4'd1,4'd0}, 1, 0, 1};
        tv[6]  = '{6'h04, 6'h00, 1'b1, 3, {4'd0,4'd0,4'd8,4'd1,4'd0}, 0, 0, 2};
        tv[7]  = '{6'h04, 6'h00, 1'b0, 3, {4'd0,4'd0,4'd8,4'd1,4'd0}, 0, 0, 1};
        tv[8]  = '{6'h02, 6'h00, 1'b0, 3, {4'd0,4'd0,4'd9,4'd1,4'd0}, 0, 0, 2};
        tv[9]  = '{6'h03, 6'h00, 1'b0, 3, {4'd0,4'd0,4'd9,4'd1,4'd0}, 1, 0, 2};
        tv[10] = '{6'h00, 6'h08, 1'b0, 3, {4'd0,4'd0,4'd9,4'd1,4'd0}, 0, 0, 2};
        tv[11] = '{6'h3f, 6'h00, 1'b0, 2, {4'd0,4'd0,4'd0,4'd1,4'd0}, 0, 0, 1};
        tv[12] = '{6'h00, 6'h00, 1'b0, 2, {4'd0,4'd0,4'd0,4'd1,4'd0}, 0, 0, 1};
        tv[13] = '{6'h00, 6'h23, 1'b0, 4, {4'd0,4'd7,4'd6,4'd1,4'd0}, 1, 0, 1};
    end

    logic [19:0] got;
    logic [19:0] sq;

    initial begin
        rst   = 1'b1;
        op    = 6'h3f;
        funct = 6'h00;
        zero  = 1'b0;
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_wen", 32'({pc_wr, ir_wr, rf_wr, dm_wr}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("reset_hold_state", 32'(state), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_reset_fetch", 32'({state, pc_wr, ir_wr}), 32'h03);

        // table-driven vectors
        for (int i = 0; i < 14; i++) begin
            int nrf, ndm, npc;
            nrf = 0; ndm = 0; npc = 0;
            op = tv[i].op; funct = tv[i].fn; zero = tv[i].z;
            sq = tv[i].seq;
            for (int c = 0; c < tv[i].len; c++) begin
                #1;
                chk($sformatf("tv%0d_st%0d", i, c), 32'(state), 32'(sq[4*c +: 4]));
                if (rf_wr) nrf++;
                if (dm_wr) ndm++;
                if (pc_wr) npc++;
                if (state == 4'd6 && i == 3)
                    chk("slt_alu_exe", 32'(alu_op), 32'd4);
                if (state == 4'd7 && i == 3)
                    chk("slt_awb", 32'({rf_wr, ra_sel}), 32'b101);
                if (state == 4'd4 && i == 0)
                    chk("lw_wd_sel", 32'(wd_sel), 32'd1);
                if (state == 4'd9 && i == 9)
                    chk("jal_out", 32'({pc_wr, npc_op, rf_wr, ra_sel, wd_sel}),
                        32'b1_10_1_10_10);
                if (state == 4'd8)
                    chk($sformatf("tv%0d_br", i), 32'({pc_wr, npc_op}),
                        32'({tv[i].z, 2'b01}));
                @(negedge clk);
            end
            #1;
            chk($sformatf("tv%0d_end", i), 32'(state), 32'd0);
            chk($sformatf("tv%0d_nrf", i), 32'(nrf), 32'(tv[i].n_rf));
            chk($sformatf("tv%0d_ndm", i), 32'(ndm), 32'(tv[i].n_dm));
            chk($sformatf("tv%0d_npc", i), 32'(npc), 32'(tv[i].n_pc));
        end

        // random instruction stream against the model
        for (int k = 0; k < 300; k++) begin
            cls_t c;
            int   n;
            int   r;
            logic [5:0] rfs [6];
            rfs[0] = 6'h21; rfs[1] = 6'h23; rfs[2] = 6'h24;
            rfs[3] = 6'h25; rfs[4] = 6'h2a; rfs[5] = 6'h08;
            r = $urandom_range(0, 11);
            funct = 6'($urandom);
            case (r)
                0: op = 6'h23;
                1: op = 6'h2b;
                2, 3: begin op = 6'h00; funct = rfs[$urandom_range(0, 5)]; end
                4: op = 6'h0d;
                5: op = 6'h0f;
                6: op = 6'h04;
                7: op = 6'h02;
                8: op = 6'h03;
                default: op = 6'($urandom);
            endcase
            c = classify(op, funct);
            n = cyc(c);
            for (int s = 0; s < n; s++) begin
                ov_t e;
                zero = 1'($urandom);
                #1;
                got = {state, pc_wr, ir_wr, rf_wr, dm_wr, npc_op, alu_op,
                       alu_src_b, ext_op, wd_sel, ra_sel};
                e = model(c, s, zero, funct);
                chk($sformatf("rnd%0d_op%0h_fn%0h_s%0d", k, op, funct, s),
                    32'(got), 32'(e));
                chk("rnd_rf_dm_excl", 32'(rf_wr & dm_wr), 32'd0);
                chk("rnd_ir_fetch", 32'(ir_wr & (state != 4'd0)), 32'd0);
                @(negedge clk);
            end
        end

        // async reset during MR of lw: no write-back may follow
        begin
            int hit, nw;
            hit = 0; nw = 0;
            op = 6'h23; funct = 6'h00;
            for (int c = 0; c < 8; c++) begin
                #1;
                if (state == 4'd3) begin
                    hit = 1;
                    break;
                end
                @(negedge clk);
            end
            chk("lw_reach_mr", 32'(hit), 32'd1);
            #2;
            rst = 1'b1;
            #1;
            chk("lw_rst_async_state", 32'(state), 32'd0);
            chk("lw_rst_wen", 32'({pc_wr, ir_wr, rf_wr, dm_wr}), 32'd0);
            op = 6'h3f;
            @(posedge clk);
            #1;
            chk("lw_rst_held", 32'({state, pc_wr, ir_wr, rf_wr, dm_wr}), 32'd0);
            @(negedge clk);
            rst = 1'b0;
            for (int c = 0; c < 6; c++) begin
                #1;
                if (rf_wr || dm_wr) nw++;
                @(negedge clk);
            end
            chk("lw_rst_no_write", 32'(nw), 32'd0);
        end

        // async reset during MW of sw
        begin
            int hit;
            hit = 0;
            #1;
            op = 6'h2b;
            @(negedge clk);
            for (int c = 0; c < 8; c++) begin
                #1;
                if (state == 4'd5) begin
                    hit = 1;
                    break;
                end
                @(negedge clk);
            end
            chk("sw_reach_mw", 32'(hit), 32'd1);
            chk("sw_mw_dm", 32'(dm_wr), 32'd1);
            #2;
            rst = 1'b1;
            #1;
            chk("sw_rst_async", 32'({state, dm_wr}), 32'd0);
            op = 6'h3f;
            @(negedge clk);
            rst = 1'b0;
            #1;
            chk("sw_rst_fetch", 32'({state, pc_wr, ir_wr}), 32'h03);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameters: none; the instruction subset and encodings are fixed by this document.
REQ-002 clk  input  1  the single system clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 op  input  6  opcode field, driven from the instruction register; valid from DCD onward.
REQ-005 funct  input  6  function field, driven from the instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 pc_wr  output  1  PC write enable.
REQ-008 ir_wr  output  1  instruction register write enable.
REQ-009 rf_wr  output  1  register file write enable.
REQ-010 dm_wr  output  1  data memory write enable.
REQ-011 npc_op  output  2  next-PC select: 00 = PC+4, 01 = branch, 10 = jump target, 11 = rs (jr).
REQ-012 alu_op  output  3  ALU function: 000 = add, 001 = sub, 010 = and, 011 = or, 100 = slt, 101 = lui.
REQ-013 alu_src_b  output  1  ALU B operand select: 0 = rt, 1 = extended immediate.
REQ-014 ext_op  output  2  immediate extension: 00 = zero-extend, 01 = sign-extend, 10 = shift left 16.
REQ-015 wd_sel  output  2  register-file write-data select: 00 = ALU, 01 = memory data register, 10 = PC+4.
REQ-016 ra_sel  output  2  register-file write-address select: 00 = rt, 01 = rd, 10 = $31.
REQ-017 state  output  4  current state, for debug.

Function
REQ-018 Supported instructions:
- R-type (op 000000): addu 100001, subu 100011, and 100100, or 100101, slt 101010, jr 001000.
- I/J-type: ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
REQ-019 States and encodings: FETCH = 0, DCD = 1, MA = 2, MR = 3, MWB = 4, MW = 5, EXE = 6, AWB = 7, BR = 8, JMP = 9.
REQ-020 Transitions:
- FETCH -> DCD unconditionally.
- DCD -> MA for lw/sw; -> EXE for R-type (except jr), ori, lui; -> BR for beq; -> JMP for j, jal, jr; -> FETCH for any undefined op or funct.
REQ-021 Further transitions:
- MA -> MR for lw, MA -> MW for sw.
- MR -> MWB.
- MWB, MW, AWB, BR, JMP -> FETCH.
- EXE -> AWB.
REQ-022 Outputs are combinational functions of state, op and funct (no output registers).
REQ-023 All write enables are 0 and all selects are 00 in every state unless stated otherwise in REQ-024 to REQ-029.
REQ-024 FETCH: ir_wr = 1, pc_wr = 1, npc_op = 00.
REQ-025 MA: alu_op = add, alu_src_b = 1, ext_op = 01.
REQ-026 MWB: rf_wr = 1, wd_sel = 01, ra_sel = 00. MW: dm_wr = 1.
REQ-027 EXE and AWB operand selection (AWB holds the same alu_op, alu_src_b and ext_op as EXE):
- R-type: alu_src_b = 0, alu_op from funct.
- ori: alu_src_b = 1, ext_op = 00, alu_op = or.
- lui: alu_src_b = 1, ext_op = 10, alu_op = lui.
REQ-028 AWB write-back: rf_wr = 1, wd_sel = 00, ra_sel = 01 for R-type, 00 for ori/lui.
REQ-029 BR: alu_op = sub, alu_src_b = 0, ext_op = 01, npc_op = 01, pc_wr = zero.
REQ-030 JMP:
- j: pc_wr = 1, npc_op = 10.
- jal: as j, plus rf_wr = 1, ra_sel = 10, wd_sel = 10.
- jr: pc_wr = 1, npc_op = 11.
REQ-031 Latency in cycles per instruction: lw 5; R-type, ori, lui, sw 4; beq, j, jal, jr 3; undefined 2.
REQ-032 At most one of rf_wr and dm_wr is 1 in any cycle.
REQ-033 ir_wr is 1 only in FETCH.
REQ-034 No state other than FETCH is entered twice without an intervening FETCH.
REQ-035 Encodings 10-15 are illegal; if one is reached, the next state is FETCH and all write enables are 0 in that cycle.

Reset
REQ-036 rst = 1 forces state = FETCH immediately, without waiting for a clock edge.
REQ-037 While rst = 1, all write enables are 0 regardless of the FETCH decode.
REQ-038 After rst is deasserted, the first rising edge executes FETCH.
REQ-039 Reset asserted mid-instruction (including during MW or MWB) aborts the instruction; no further writes are issued.

Verification
REQ-040 Reset release, op = 100011 (lw): state sequence 0,1,2,3,4,0; rf_wr = 1 only in state 4, with wd_sel = 01.
REQ-041 op = 101011 (sw): states 0,1,2,5,0; dm_wr = 1 only in state 5; rf_wr = 0 throughout.
REQ-042 beq: with zero = 1, pc_wr = 1 in state 8 with npc_op = 01; with zero = 0, pc_wr = 0 in state 8; 3 cycles in both cases.
REQ-043 jal: JMP state drives pc_wr = 1, npc_op = 10, rf_wr = 1, ra_sel = 10, wd_sel = 10.
REQ-044 R-type with funct = 101010: alu_op = 100 in EXE; AWB drives rf_wr = 1, ra_sel = 01. Undefined op = 111111: DCD -> FETCH with no write enable ever asserted.
REQ-045 rst pulsed asynchronously during state 3 (lw): state reads 0 within the same cycle and no rf_wr pulse follows.
